jtdd_sdram_arb: RTL

// - Round-robin arbiter sharing the single SDRAM read port among SLOTS ROM requesters
//   (char, scroll, object, main, sound, ADPCM, MCU fetch units of the game top).
// - Each slot keeps a one-word cache (tag + data); hits answer without SDRAM traffic, misses queue.
// - Sits between the per-unit rom_addr/rom_cs/rom_ok interfaces and the frame SDRAM controller.

---
 rtl/jtdd_sdram_pkg.sv | 13 +
 rtl/jtdd_slot_cache.sv | 61 ++++++
 rtl/jtdd_sdram_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jtdd_sdram_pkg.sv
// Shared definitions for the SDRAM ROM arbiter: FSM state encodings and default bus widths.
package jtdd_sdram_pkg;

    localparam int DEF_AW = 22;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/jtdd_slot_cache.sv
// One-word cache for a single ROM requester: tag/valid/data registers, hit compare and slot_ok flag.
module jtdd_slot_cache
    import jtdd_sdram_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          hit,
    output logic [DW-1:0] dout,
    output logic          ok
);

    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;
    logic          ok_q, ok_d;

    assign hit  = valid_q & (tag_q == addr);
    assign dout = data_q;
    assign ok   = ok_q;

    // A fill answers the requester in the same edge it is written, so slot_ok
    // rises the cycle right after data_rdy when the address still matches.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_addr;
            data_d  = fill_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
        ok_d = cs & ~flush & (fill_en ? (fill_addr == addr) : hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: rtl/jtdd_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS cached ROM requesters.
module jtdd_sdram_arb
    import jtdd_sdram_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [SLOTS-1:0]    slot_ok,
    input  logic                downloading,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int PW = $clog2(SLOTS);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          refresh_q, refresh_d;

    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] pending;
    logic [SLOTS-1:0] fill_en;
    logic             fill_now;
    logic [PW-1:0]    pick;
    logic             pick_vld;
    logic [PW-1:0]    grant_next;
    logic [PW:0]      scan;
    logic [AW-1:0]    addr_arr [SLOTS];

    // The slot being served is masked out of pending so its own outstanding
    // miss cannot be granted a second time while the transfer is in flight.
    for (genvar n = 0; n < SLOTS; n++) begin : g_slot
        assign addr_arr[n] = slot_addr[n*AW +: AW];
        assign pending[n]  = slot_cs[n] & ~hit[n] &
                             ~((state_q != ST_IDLE) & (grant_q == PW'(n)));
        assign fill_en[n]  = fill_now & (grant_q == PW'(n));

        jtdd_slot_cache #(
            .AW (AW),
            .DW (DW)
        ) u_cache (
            .clk       (clk),
            .rst       (rst),
            .flush     (downloading),
            .cs        (slot_cs[n]),
            .addr      (addr_arr[n]),
            .fill_en   (fill_en[n]),
            .fill_addr (addr_q),
            .fill_data (data_read),
            .hit       (hit[n]),
            .dout      (slot_dout[n*DW +: DW]),
            .ok        (slot_ok[n])
        );
    end

    always_comb begin
        pick     = ptr_q;
        pick_vld = 1'b0;
        scan     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(i);
            if (scan >= (PW+1)'(SLOTS)) begin
                scan = scan - (PW+1)'(SLOTS);
            end
            if (!pick_vld && pending[scan[PW-1:0]]) begin
                pick     = scan[PW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign grant_next = (grant_q == PW'(SLOTS-1)) ? '0 : grant_q + 1'b1;

    // An ack arriving together with data_rdy is taken as ack followed by data,
    // so the store happens straight from REQ without visiting WAIT.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        req_d    = req_q;
        addr_d   = addr_q;
        fill_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!downloading && pick_vld) begin
                    grant_d = pick;
                    addr_d  = addr_arr[pick];
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    if (data_rdy) begin
                        fill_now = 1'b1;
                        ptr_d    = grant_next;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_rdy) begin
                    fill_now = 1'b1;
                    ptr_d    = grant_next;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (downloading) begin
            state_d  = ST_IDLE;
            req_d    = 1'b0;
            fill_now = 1'b0;
        end
        refresh_d = (state_q == ST_IDLE) & ~(|pending) & ~downloading;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            refresh_q <= refresh_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = refresh_q;

endmodule
